// File: rtl/wait_state_memory_if.sv
// Request/done handshake bundle for the wait-state main memory.
// The master drives the request; the slave reports busy/done/err/rdata.
interface wait_state_memory_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/wait_state_memory.sv
// Single-port main memory with programmable wait states,
// request/done handshake, range checking and a debug read port.
module wait_state_memory #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  wait_state_memory_if.slave bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic in_rng;
  logic dbg_rng;
  logic access;
  logic mem_we;

  assign in_rng  = {1'b0, addr_q} < LIMIT;
  assign dbg_rng = {1'b0, dbg_addr} < LIMIT;
  assign access  = (state == WAIT) && (cnt == 4'd0);
  assign mem_we  = access && we_q && in_rng;

  // Array kept out of the reset domain; an async reset drops state
  // to IDLE, which removes mem_we before the next edge.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[addr_q[IDX_W-1:0]] <= wdata_q;
  end

  assign dbg_data = dbg_rng ? mem[dbg_addr[IDX_W-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            we_q    <= bus.we;
            wdata_q <= bus.wdata;
            cnt     <= 4'(WAIT_CYCLES);
            busy_q  <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (in_rng && !we_q)
              rdata_q <= mem[addr_q[IDX_W-1:0]];
            err_q  <= !in_rng;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench for wait_state_memory: handshake timing, latency
// sweep, ignored requests, range errors and reset abort.
module tb_wait_state_memory;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wait_state_memory_if #(.DATA_W(16), .ADDR_W(12)) b2 ();
  wait_state_memory_if #(.DATA_W(16), .ADDR_W(12)) b0 ();
  wait_state_memory_if #(.DATA_W(16), .ADDR_W(12)) b15 ();

  logic [11:0] dbg2;
  logic [15:0] dd2;
  logic [15:0] dd0;
  logic [15:0] dd15;

  wait_state_memory #(
    .DATA_W(16), .ADDR_W(12), .DEPTH(2048), .WAIT_CYCLES(2)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave),
    .dbg_addr(dbg2), .dbg_data(dd2)
  );

  wait_state_memory #(
    .DATA_W(16), .ADDR_W(12), .DEPTH(4096), .WAIT_CYCLES(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave),
    .dbg_addr(12'h000), .dbg_data(dd0)
  );

  wait_state_memory #(
    .DATA_W(16), .ADDR_W(12), .DEPTH(4096), .WAIT_CYCLES(15)
  ) u15 (
    .clk(clk), .rst_n(rst_n), .bus(b15.slave),
    .dbg_addr(12'h000), .dbg_data(dd15)
  );

  int checks = 0;
  int failures = 0;

  int          done_at;
  int          done_n;
  int          busy_n;
  logic [15:0] rd_done;
  logic        err_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run2(input logic w, input logic [11:0] a,
                      input logic [15:0] d, input bit inject);
    b2.we    = w;
    b2.addr  = a;
    b2.wdata = d;
    b2.req   = 1'b1;
    tick();
    b2.req   = 1'b0;
    done_at  = -1;
    done_n   = 0;
    busy_n   = 0;
    rd_done  = '0;
    err_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!b2.busy) break;
      busy_n++;
      if (b2.done) begin
        done_n++;
        if (done_at < 0) done_at = k;
        rd_done  = b2.rdata;
        err_done = b2.err;
      end
      if (inject && k == 1) begin
        b2.req   = 1'b1;
        b2.we    = 1'b1;
        b2.addr  = 12'h800;
        b2.wdata = 16'hFFFF;
      end else begin
        b2.req = 1'b0;
      end
      tick();
    end
    b2.req = 1'b0;
  endtask

  task automatic peek(input logic [11:0] a, output logic [15:0] v);
    dbg2 = a;
    #1;
    v = dd2;
  endtask

  initial begin
    int d0;
    int d15;
    int n0;
    int n15;
    logic [15:0] v;

    rst_n = 1'b0;
    dbg2  = '0;
    b2.req = 1'b0;  b2.we = 1'b0;  b2.addr = '0;  b2.wdata = '0;
    b0.req = 1'b0;  b0.we = 1'b0;  b0.addr = '0;  b0.wdata = '0;
    b15.req = 1'b0; b15.we = 1'b0; b15.addr = '0; b15.wdata = '0;
    #2;
    u2.mem[12'h740] = 16'h0000;
    u2.mem[12'h741] = 16'h0C3C;
    u2.mem[12'h800 - 12'h800] = 16'h0000;
    u2.mem[12'h100] = 16'h1111;
    u2.mem[12'h010] = 16'h0A0A;
    u0.mem[12'h123]  = 16'h4321;
    u15.mem[12'h123] = 16'h4321;

    tick();
    tick();
    chk("rst_busy", 32'(b2.busy), 32'h0);
    chk("rst_done", 32'(b2.done), 32'h0);
    chk("rst_err", 32'(b2.err), 32'h0);
    chk("rst_rdata", 32'(b2.rdata), 32'h0);
    rst_n = 1'b1;
    tick();

    run2(1'b1, 12'h740, 16'h1234, 1'b0);
    chk("wr_done_at", 32'(done_at), 32'd3);
    chk("wr_busy_n", 32'(busy_n), 32'd4);
    chk("wr_done_n", 32'(done_n), 32'd1);
    chk("wr_err", 32'(err_done), 32'h0);
    peek(12'h740, v);
    chk("wr_dbg", 32'(v), 32'h1234);

    run2(1'b0, 12'h740, 16'h0000, 1'b0);
    chk("rd_done_at", 32'(done_at), 32'd3);
    chk("rd_rdata", 32'(rd_done), 32'h1234);
    chk("rd_hold", 32'(b2.rdata), 32'h1234);

    run2(1'b0, 12'h741, 16'h0000, 1'b1);
    chk("ign_done_n", 32'(done_n), 32'd1);
    chk("ign_busy_n", 32'(busy_n), 32'd4);
    chk("ign_rdata", 32'(rd_done), 32'h0C3C);
    tick();
    chk("ign_no_busy", 32'(b2.busy), 32'h0);
    peek(12'h800, v);
    chk("ign_mem800", 32'(v), 32'h0);

    run2(1'b0, 12'h900, 16'h0000, 1'b0);
    chk("oor_rd_done_n", 32'(done_n), 32'd1);
    chk("oor_rd_err", 32'(err_done), 32'h1);
    chk("oor_rd_hold", 32'(rd_done), 32'h0C3C);
    peek(12'h900, v);
    chk("oor_dbg", 32'(v), 32'h0);

    run2(1'b1, 12'h900, 16'hDEAD, 1'b0);
    chk("oor_wr_err", 32'(err_done), 32'h1);
    peek(12'h100, v);
    chk("oor_wr_alias", 32'(v), 32'h1111);
    chk("oor_wr_rdata", 32'(b2.rdata), 32'h0C3C);

    b0.we = 1'b0;  b0.addr = 12'h123;
    b15.we = 1'b0; b15.addr = 12'h123;
    b0.req = 1'b1; b15.req = 1'b1;
    tick();
    b0.req = 1'b0; b15.req = 1'b0;
    d0 = -1; d15 = -1; n0 = 0; n15 = 0;
    for (int k = 0; k < 24; k++) begin
      if (b0.done) begin
        n0++;
        if (d0 < 0) d0 = k;
      end
      if (b15.done) begin
        n15++;
        if (d15 < 0) d15 = k;
      end
      tick();
    end
    chk("w0_done_at", 32'(d0), 32'd1);
    chk("w0_done_n", 32'(n0), 32'd1);
    chk("w0_rdata", 32'(b0.rdata), 32'h4321);
    chk("w15_done_at", 32'(d15), 32'd16);
    chk("w15_done_n", 32'(n15), 32'd1);

    b2.we    = 1'b1;
    b2.addr  = 12'h010;
    b2.wdata = 16'hBEEF;
    b2.req   = 1'b1;
    tick();
    b2.req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(b2.busy), 32'h0);
    chk("abort_done", 32'(b2.done), 32'h0);
    chk("abort_err", 32'(b2.err), 32'h0);
    chk("abort_rdata", 32'(b2.rdata), 32'h0);
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    peek(12'h010, v);
    chk("abort_mem", 32'(v), 32'h0A0A);
    tick();
    run2(1'b0, 12'h010, 16'h0000, 1'b0);
    chk("post_done_at", 32'(done_at), 32'd3);
    chk("post_rdata", 32'(rd_done), 32'h0A0A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
